// File: rtl/tx_eth_frame_feeder.sv
// Buffers one host frame in RAM, then feeds it byte by byte to the MAC Tx stage, zero-padded to MIN_LEN.
// Latency: byte 0 is valid when Transmit_of_Data_RQ rises; the next byte appears one cycle after each strobe.
// Backpressure: Buf_Ready drops from the last host byte until the inter-frame gap after the MAC finishes.
module tx_eth_frame_feeder #(
  parameter int BUF_DEPTH = 2048,
  parameter int MIN_LEN   = 60,
  parameter int IFG_CLKS  = 96
) (
  input  logic       System_Clock,
  input  logic       Reset_n,
  input  logic       Wr_En,
  input  logic [7:0] Wr_Data,
  input  logic       Wr_Last,
  output logic       Buf_Ready,
  output logic       Overflow,
  output logic       Transmit_of_Data_RQ,
  output logic [7:0] Data_to_Transmit,
  input  logic       Byte_Readed_Strob,
  input  logic       Eth_Tx_In_Progress,
  output logic       Frame_Done
);
  localparam int AW = $clog2(BUF_DEPTH);
  localparam int CW = AW + 1;
  localparam int GW = (IFG_CLKS > 1) ? $clog2(IFG_CLKS) : 1;
  localparam logic [CW-1:0] LAST_SLOT = CW'(BUF_DEPTH - 1);
  localparam logic [CW-1:0] MIN_LEN_C = CW'(MIN_LEN);
  localparam logic [GW-1:0] GAP_END   = GW'(IFG_CLKS - 1);

  typedef enum logic [1:0] {FILL, SEND, DRAIN, GAP} state_t;

  // Assertion is immediate; release is retimed so no flop sees it near an edge.
  logic [1:0] rst_sync_q;
  logic       rst_n_int;

  always_ff @(posedge System_Clock or negedge Reset_n) begin
    if (!Reset_n) rst_sync_q <= 2'b00;
    else          rst_sync_q <= {rst_sync_q[0], 1'b1};
  end

  assign rst_n_int = rst_sync_q[1];

  state_t        state_q, state_d;
  logic [CW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] len_q, len_d;
  logic [CW-1:0] send_len_q, send_len_d;
  logic [CW-1:0] rd_cnt_q, rd_cnt_d;
  logic [GW-1:0] gap_cnt_q, gap_cnt_d;
  logic          discard_q, discard_d;
  logic          overflow_q, overflow_d;
  logic          mem_we;
  logic          frame_done;
  logic [CW-1:0] frame_len;
  logic [AW-1:0] wr_addr, rd_addr;
  logic [7:0]    rd_dat_q;
  logic [7:0]    mem [BUF_DEPTH];

  assign frame_len = wr_ptr_q + CW'(1);

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    len_d      = len_q;
    send_len_d = send_len_q;
    rd_cnt_d   = rd_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    discard_d  = discard_q;
    overflow_d = 1'b0;
    mem_we     = 1'b0;
    frame_done = 1'b0;
    case (state_q)
      FILL: begin
        if (Wr_En) begin
          if (discard_q) begin
            // Tail of a dropped frame: swallow bytes until its last one.
            if (Wr_Last) discard_d = 1'b0;
          end else if (Wr_Last) begin
            mem_we     = 1'b1;
            len_d      = frame_len;
            send_len_d = (frame_len < MIN_LEN_C) ? MIN_LEN_C : frame_len;
            wr_ptr_d   = '0;
            rd_cnt_d   = '0;
            state_d    = SEND;
          end else if (wr_ptr_q == LAST_SLOT) begin
            overflow_d = 1'b1;
            wr_ptr_d   = '0;
            discard_d  = 1'b1;
          end else begin
            mem_we   = 1'b1;
            wr_ptr_d = frame_len;
          end
        end
      end
      SEND: begin
        if (Byte_Readed_Strob) begin
          rd_cnt_d = rd_cnt_q + CW'(1);
          if (rd_cnt_d == send_len_q) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (!Eth_Tx_In_Progress) begin
          gap_cnt_d = '0;
          state_d   = GAP;
        end
      end
      GAP: begin
        if (gap_cnt_q == GAP_END) begin
          frame_done = 1'b1;
          state_d    = FILL;
        end else begin
          gap_cnt_d = gap_cnt_q + GW'(1);
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge System_Clock or negedge rst_n_int) begin
    if (!rst_n_int) begin
      state_q    <= FILL;
      wr_ptr_q   <= '0;
      len_q      <= '0;
      send_len_q <= '0;
      rd_cnt_q   <= '0;
      gap_cnt_q  <= '0;
      discard_q  <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      len_q      <= len_d;
      send_len_q <= send_len_d;
      rd_cnt_q   <= rd_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
      discard_q  <= discard_d;
      overflow_q <= overflow_d;
    end
  end

  // Read is addressed by the next rd_cnt so the byte is ready as SEND starts;
  // the bypass covers a one-byte frame whose only byte is written on that same edge.
  assign wr_addr = wr_ptr_q[AW-1:0];
  assign rd_addr = rd_cnt_d[AW-1:0];

  always_ff @(posedge System_Clock) begin
    if (mem_we) mem[wr_addr] <= Wr_Data;
    rd_dat_q <= (mem_we && (wr_addr == rd_addr)) ? Wr_Data : mem[rd_addr];
  end

  assign Buf_Ready           = (state_q == FILL);
  assign Transmit_of_Data_RQ = (state_q == SEND);
  assign Data_to_Transmit    = ((state_q == SEND) && (rd_cnt_q < len_q)) ? rd_dat_q : 8'h00;
  assign Overflow            = overflow_q;
  assign Frame_Done          = frame_done;
endmodule

// File: tb/tb_tx_eth_frame_feeder.sv
// Scoreboard bench: host writer pushes expected padded frames; a MAC model pops and compares on each strobe.
module tb_tx_eth_frame_feeder;
  localparam int BUF_DEPTH = 2048;
  localparam int MIN_LEN   = 60;
  localparam int IFG_CLKS  = 96;

  logic       System_Clock = 1'b0;
  logic       Reset_n;
  logic       Wr_En = 1'b0;
  logic [7:0] Wr_Data = 8'h00;
  logic       Wr_Last = 1'b0;
  logic       Buf_Ready, Overflow, Transmit_of_Data_RQ, Frame_Done;
  logic [7:0] Data_to_Transmit;
  logic       Byte_Readed_Strob = 1'b0;
  logic       Eth_Tx_In_Progress = 1'b0;

  int errors = 0;
  int checks = 0;
  logic [7:0] exp_q[$];
  int         exp_len_q[$];
  int mac_period = 16;
  int mac_hold = 4;
  bit spurious_en = 1'b0;
  bit mac_abort = 1'b0;
  int frames_done = 0;
  int strobe_cnt = 0;
  int ovf_cnt = 0;
  int ovf_at = -1;

  tx_eth_frame_feeder #(.BUF_DEPTH(BUF_DEPTH), .MIN_LEN(MIN_LEN), .IFG_CLKS(IFG_CLKS)) dut (
    .System_Clock(System_Clock),
    .Reset_n(Reset_n),
    .Wr_En(Wr_En),
    .Wr_Data(Wr_Data),
    .Wr_Last(Wr_Last),
    .Buf_Ready(Buf_Ready),
    .Overflow(Overflow),
    .Transmit_of_Data_RQ(Transmit_of_Data_RQ),
    .Data_to_Transmit(Data_to_Transmit),
    .Byte_Readed_Strob(Byte_Readed_Strob),
    .Eth_Tx_In_Progress(Eth_Tx_In_Progress),
    .Frame_Done(Frame_Done)
  );

  always #5 System_Clock = ~System_Clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  // MAC model and scoreboard monitor.
  initial begin : mac_monitor
    int remaining, since, drain_hold, gap_wait, done_during_hold;
    bit in_frame, check_rq_low, check_rdy_next, rq_flagged;
    logic [7:0] exp_b;
    remaining = 0; since = 0; drain_hold = 0; gap_wait = -1; done_during_hold = 0;
    in_frame = 0; check_rq_low = 0; check_rdy_next = 0; rq_flagged = 0;
    forever begin
      @(negedge System_Clock);
      Byte_Readed_Strob = 1'b0;
      if (mac_abort) begin
        in_frame = 0; check_rq_low = 0; check_rdy_next = 0; rq_flagged = 0;
        drain_hold = 0; gap_wait = -1;
        Eth_Tx_In_Progress = 1'b0;
        exp_q.delete();
        exp_len_q.delete();
        mac_abort = 1'b0;
      end else begin
        if (check_rdy_next) begin
          check("buf_ready_after_done", Buf_Ready, 1);
          check_rdy_next = 0;
        end
        if (check_rq_low) begin
          check("rq_low_after_last_strobe", Transmit_of_Data_RQ, 0);
          check_rq_low = 0;
        end
        if (gap_wait >= 0) begin
          gap_wait++;
          if (Frame_Done === 1'b1) begin
            check("ifg_cycles", gap_wait, IFG_CLKS);
            check("buf_ready_at_done", Buf_Ready, 0);
            gap_wait = -1;
            check_rdy_next = 1;
            frames_done++;
          end else if (gap_wait > IFG_CLKS + 20) begin
            fail("frame_done_timeout");
            gap_wait = -1;
            frames_done++;
          end
        end else if (Frame_Done === 1'b1) begin
          if (drain_hold > 0) done_during_hold++;
          else fail("spurious_frame_done");
        end
        if (drain_hold > 0) begin
          drain_hold--;
          if (drain_hold == 0) begin
            check("no_done_while_busy", done_during_hold, 0);
            check("buf_ready_while_busy", Buf_Ready, 0);
            Eth_Tx_In_Progress = 1'b0;
            gap_wait = 0;
          end
        end
        if (in_frame) begin
          if (Transmit_of_Data_RQ !== 1'b1) begin
            fail("rq_dropped_early");
            in_frame = 0;
          end else begin
            since++;
            if (since >= mac_period) begin
              exp_b = exp_q.pop_front();
              check("tx_byte", Data_to_Transmit, exp_b);
              Byte_Readed_Strob = 1'b1;
              since = 0;
              remaining--;
              strobe_cnt++;
              if (remaining == 0) begin
                in_frame = 0;
                check_rq_low = 1;
                drain_hold = mac_hold;
                done_during_hold = 0;
              end
            end
          end
        end else if (Transmit_of_Data_RQ === 1'b1 && drain_hold == 0 && gap_wait < 0) begin
          if (exp_len_q.size() == 0) begin
            if (!rq_flagged) fail("unexpected_rq");
            rq_flagged = 1;
          end else begin
            remaining = exp_len_q.pop_front();
            in_frame = 1;
            since = 0;
            strobe_cnt = 0;
            Eth_Tx_In_Progress = 1'b1;
          end
        end else begin
          if (Transmit_of_Data_RQ !== 1'b1) rq_flagged = 0;
          if (spurious_en && Transmit_of_Data_RQ === 1'b0 && $urandom_range(0, 7) == 0)
            Byte_Readed_Strob = 1'b1;
        end
      end
    end
  end

  task automatic sample_ovf(input int idx);
    if (Overflow === 1'b1) begin
      ovf_cnt++;
      ovf_at = idx;
    end
  endtask

  // Host writer; the reference model is simply the byte list padded with zeros to MIN_LEN.
  task automatic write_frame(input int len, input bit rnd);
    logic [7:0] data[$];
    int n;
    n = 0;
    while (Buf_Ready !== 1'b1 && n < 2000) begin
      @(negedge System_Clock);
      n++;
    end
    if (Buf_Ready !== 1'b1) fail("buf_ready_timeout");
    for (int i = 0; i < len; i++) data.push_back(rnd ? 8'($urandom) : 8'(i));
    if (len <= BUF_DEPTH) begin
      exp_len_q.push_back((len < MIN_LEN) ? MIN_LEN : len);
      foreach (data[i]) exp_q.push_back(data[i]);
      for (int i = len; i < MIN_LEN; i++) exp_q.push_back(8'h00);
    end
    for (int i = 0; i < len; i++) begin
      if (rnd) begin
        while ($urandom_range(0, 3) == 0) begin
          @(negedge System_Clock);
          sample_ovf(i - 1);
          Wr_En = 1'b0;
          Wr_Last = 1'b0;
        end
      end
      @(negedge System_Clock);
      sample_ovf(i - 1);
      Wr_En = 1'b1;
      Wr_Data = data[i];
      Wr_Last = (i == len - 1);
    end
    @(negedge System_Clock);
    sample_ovf(len - 1);
    Wr_En = 1'b0;
    Wr_Last = 1'b0;
  endtask

  // Wait for a frame to complete, optionally throwing junk writes at the block while it is busy.
  task automatic wait_done(input int target, input int bud, input bit junk);
    int n;
    n = 0;
    while (frames_done < target && n < bud) begin
      @(negedge System_Clock);
      n++;
      if (junk && Buf_Ready === 1'b0 && $urandom_range(0, 3) == 0) begin
        Wr_En = 1'b1;
        Wr_Data = 8'($urandom);
        Wr_Last = 1'($urandom);
      end else begin
        Wr_En = 1'b0;
        Wr_Last = 1'b0;
      end
    end
    Wr_En = 1'b0;
    Wr_Last = 1'b0;
    check("frames_done", frames_done, target);
  endtask

  function automatic int budget(input int len);
    return ((len < MIN_LEN) ? MIN_LEN : len) * (mac_period + 1) + mac_hold + IFG_CLKS + 300;
  endfunction

  initial begin : watchdog
    #1000000;
    errors++;
    $display("FAIL watchdog: time limit reached");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int n, fd, len;
    int lens[4];
    lens = '{1, 59, 60, 61};
    Reset_n = 1'b1;
    #2 Reset_n = 1'b0;
    #1;
    check("reset_rq", Transmit_of_Data_RQ, 0);
    check("reset_data", Data_to_Transmit, 8'h00);
    check("reset_overflow", Overflow, 0);
    check("reset_frame_done", Frame_Done, 0);
    check("reset_buf_ready", Buf_Ready, 1);
    repeat (3) @(posedge System_Clock);
    @(negedge System_Clock) Reset_n = 1'b1;
    repeat (4) @(negedge System_Clock);

    // 100 incrementing bytes, MAC strobing every 16 clocks.
    mac_period = 16; mac_hold = 4;
    fd = frames_done;
    write_frame(100, 1'b0);
    wait_done(fd + 1, budget(100), 1'b0);

    // Short frame padded to MIN_LEN.
    fd = frames_done;
    write_frame(10, 1'b0);
    wait_done(fd + 1, budget(10), 1'b0);

    // MAC stays busy long after RQ drops.
    mac_period = 4; mac_hold = 500;
    fd = frames_done;
    write_frame(20, 1'b1);
    wait_done(fd + 1, budget(20), 1'b1);
    mac_hold = 4;

    // One byte too many: dropped, then a normal frame.
    mac_period = 3;
    write_frame(BUF_DEPTH + 1, 1'b0);
    repeat (30) @(negedge System_Clock);
    check("ovf_count", ovf_cnt, 1);
    check("ovf_byte_index", ovf_at, BUF_DEPTH - 1);
    check("ovf_rq_low", Transmit_of_Data_RQ, 0);
    check("ovf_buf_ready", Buf_Ready, 1);
    fd = frames_done;
    write_frame(64, 1'b0);
    wait_done(fd + 1, budget(64), 1'b0);

    // Exactly full buffer.
    fd = frames_done;
    write_frame(BUF_DEPTH, 1'b1);
    wait_done(fd + 1, budget(BUF_DEPTH), 1'b0);
    check("full_frame_no_ovf", ovf_cnt, 1);

    // Junk writes mid-SEND, then reset at strobe 20.
    mac_period = 6;
    strobe_cnt = 0;
    fd = frames_done;
    write_frame(80, 1'b1);
    n = 0;
    while (strobe_cnt < 10 && n < 2000) begin @(posedge System_Clock); n++; end
    for (int i = 0; i < 3; i++) begin
      @(negedge System_Clock);
      Wr_En = 1'b1; Wr_Data = 8'hEE; Wr_Last = (i == 2);
    end
    @(negedge System_Clock);
    Wr_En = 1'b0; Wr_Last = 1'b0;
    n = 0;
    while (strobe_cnt < 20 && n < 2000) begin @(posedge System_Clock); n++; end
    check("strobes_before_reset", strobe_cnt, 20);
    #2 Reset_n = 1'b0;
    mac_abort = 1'b1;
    #1;
    check("midsend_reset_rq", Transmit_of_Data_RQ, 0);
    check("midsend_reset_buf_ready", Buf_Ready, 1);
    check("midsend_reset_data", Data_to_Transmit, 8'h00);
    repeat (3) @(posedge System_Clock);
    @(negedge System_Clock) Reset_n = 1'b1;
    repeat (4) @(negedge System_Clock);
    check("after_reset_rq", Transmit_of_Data_RQ, 0);
    check("after_reset_buf_ready", Buf_Ready, 1);
    write_frame(30, 1'b1);
    wait_done(fd + 1, budget(30), 1'b0);

    // Boundary lengths around MIN_LEN, then random frames with junk writes and stray strobes.
    spurious_en = 1'b1;
    for (int f = 0; f < 19; f++) begin
      len = (f < 4) ? lens[f] : $urandom_range(1, 200);
      mac_period = $urandom_range(3, 6);
      mac_hold = $urandom_range(1, 10);
      fd = frames_done;
      write_frame(len, 1'b1);
      wait_done(fd + 1, budget(len), 1'b1);
    end
    spurious_en = 1'b0;

    repeat (5) @(negedge System_Clock);
    check("scoreboard_bytes_left", exp_q.size(), 0);
    check("scoreboard_frames_left", exp_len_q.size(), 0);
    check("final_ovf_count", ovf_cnt, 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/tx_eth_frame_feeder.md
TX_ETH_FRAME_FEEDER -- requirements
Module: tx_eth_frame_feeder

Interface
REQ-001 Parameter BUF_DEPTH, default 2048: frame buffer size in bytes; power of two.
REQ-002 Parameter MIN_LEN, default 60: minimum bytes sent per frame (pre-CRC); shorter frames are zero-padded.
REQ-003 Parameter IFG_CLKS, default 96: idle System_Clock cycles enforced after Eth_Tx_In_Progress falls.
REQ-004 System_Clock  in  1  single clock for all logic.
REQ-005 Reset_n  in  1  reset, asynchronous, active-low.
REQ-006 Wr_En  in  1  host byte write strobe.
REQ-007 Wr_Data  in  8  host byte.
REQ-008 Wr_Last  in  1  qualifies Wr_En; marks the final byte of a frame.
REQ-009 Buf_Ready  out  1  high = host writes are accepted.
REQ-010 Overflow  out  1  1-cycle strobe: frame dropped, too long.
REQ-011 Transmit_of_Data_RQ  out  1  to the MAC Tx stage; held high while frame bytes remain.
REQ-012 Data_to_Transmit  out  8  current byte presented to the MAC.
REQ-013 Byte_Readed_Strob  in  1  1-cycle MAC ack; the MAC has captured Data_to_Transmit.
REQ-014 Eth_Tx_In_Progress  in  1  MAC busy flag.
REQ-015 Frame_Done  out  1  1-cycle strobe when the IFG completes after a frame.

Function
REQ-016 FSM states: FILL, SEND, DRAIN, GAP; reset state FILL.
REQ-017 FILL: Buf_Ready=1; each Wr_En writes Wr_Data at wr_ptr; wr_ptr increments.
REQ-018 Wr_En with Wr_Last in FILL: the byte is stored; len latches wr_ptr+1; wr_ptr clears; next state SEND.
REQ-019 Overflow: Wr_En with wr_ptr==BUF_DEPTH-1 and Wr_Last=0 drops the frame.
  - The byte is not stored.
  - Overflow pulses for 1 cycle; wr_ptr clears; state stays FILL.
  - Further bytes up to and including the next Wr_Last are discarded; Buf_Ready stays high.
REQ-020 A frame of exactly BUF_DEPTH bytes (Wr_Last on the last slot) is legal.
REQ-021 Wr_En outside FILL is ignored; Buf_Ready=0 in SEND, DRAIN and GAP.
REQ-022 SEND entry: send_len = max(len, MIN_LEN); rd_cnt=0; Transmit_of_Data_RQ rises the cycle SEND is entered.
REQ-023 Data_to_Transmit timing:
  - Valid (byte 0) no later than the cycle RQ rises.
  - Holds the buffer byte at rd_cnt while rd_cnt<len, else 8'h00 (pad).
  - Updates to the next byte within 2 cycles after each Byte_Readed_Strob.
  - Otherwise stable.
REQ-024 Each Byte_Readed_Strob in SEND increments rd_cnt.
REQ-025 End of frame: when the strobe brings rd_cnt to send_len, RQ drops the next cycle and the state moves to DRAIN.
REQ-026 DRAIN: wait for Eth_Tx_In_Progress==0, then move to GAP with gap_cnt=0.
REQ-027 GAP: gap_cnt increments each cycle. At gap_cnt==IFG_CLKS-1:
  - Frame_Done pulses for 1 cycle.
  - The state moves to FILL.
REQ-028 Byte_Readed_Strob outside SEND is ignored and has no effect on any counter.
REQ-029 Counter widths:
  - wr_ptr, len, rd_cnt, send_len: log2(BUF_DEPTH)+1 bits; no wrap occurs.
  - gap_cnt: sized for IFG_CLKS.
REQ-030 Buffer: inferred single-port-write / single-port-read synchronous RAM; contents are not reset.

Reset
REQ-031 Reset_n low asynchronously forces:
  - state FILL;
  - wr_ptr, len, rd_cnt, gap_cnt = 0;
  - the discard flag cleared;
  - Transmit_of_Data_RQ=0, Data_to_Transmit=8'h00, Overflow=0, Frame_Done=0, Buf_Ready=1.
REQ-032 Reset mid-SEND aborts the frame; RQ drops immediately; after release the block is in FILL with no frame pending.
REQ-033 Reset release is synchronised internally; the first active edge after deassertion behaves as FILL.

Verification
REQ-034 Write 100 bytes 0x00..0x63 (Wr_Last on 0x63); model the MAC strobing every 16 clocks.
  - Expect RQ high for exactly 100 strobes; bytes in order.
  - Expect RQ low 1 cycle after the 100th strobe.
  - After In_Progress falls, expect Frame_Done 96 cycles later and Buf_Ready=1.
REQ-035 Write a 10-byte frame -> 60 strobes; bytes 0-9 from the buffer, bytes 10-59 = 0x00; RQ drops after strobe 60.
REQ-036 Write 2049 bytes with Wr_Last on byte 2049 ->
  - Overflow pulses once at byte 2048.
  - RQ never rises; Buf_Ready stays 1.
  - Then a 64-byte frame transmits normally.
REQ-037 Write exactly 2048 bytes -> no Overflow; 2048 strobes accepted; last byte correct.
REQ-038 Mid-SEND, apply Wr_En pulses and assert Reset_n=0 for 3 cycles at strobe 20 ->
  - Writes during SEND are ignored.
  - RQ=0 asynchronously during reset; state FILL after release.
  - A subsequent frame starts at byte 0.
REQ-039 Hold Eth_Tx_In_Progress high for 500 cycles after RQ drops -> no Frame_Done and Buf_Ready=0 until In_Progress falls plus 96 cycles.
